// File: rtl/reg_native_mem_pkg.sv
// Shared types and helpers for the native-interface SRAM target adapter.
package reg_native_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } state_t;

   typedef enum logic [1:0] {
      OP_WR,
      OP_RD,
      OP_ILL
   } op_t;

   localparam int RD_LATENCY_MAX = 4;

   // Exactly one of wr_en/rd_en must be set; anything else is an illegal op.
   function automatic op_t decode_op(input logic wr_en, input logic rd_en);
      op_t op;
      case ({wr_en, rd_en})
         2'b10:   op = OP_WR;
         2'b01:   op = OP_RD;
         default: op = OP_ILL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/reg_native_ack_buf.sv
// Acknowledge holding buffer: keeps ack_vld and rd_data (and ack_err when
// REG_NATIVE_MEM_TARGET_ERR_EN is defined) stable until the FSM clears them.
module reg_native_ack_buf
   import reg_native_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] load_data,
`ifdef REG_NATIVE_MEM_TARGET_ERR_EN
   input  logic                  load_err,
   output logic                  ack_err,
`endif
   output logic                  ack_vld,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic                  vld_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Acknowledge valid flag: set on load, dropped on the handshake.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_q <= 1'b0;
      end else if (load) begin
         vld_q <= 1'b1;
      end else if (clear) begin
         vld_q <= 1'b0;
      end
   end

   // Response data register; no reset needed because the output is gated by vld_q.
   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= load_data;
      end
   end

`ifdef REG_NATIVE_MEM_TARGET_ERR_EN
   logic err_q;

   // Error flag travels with the acknowledge and clears together with it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else if (load) begin
         err_q <= load_err;
      end else if (clear) begin
         err_q <= 1'b0;
      end
   end

   assign ack_err = err_q;
`endif

   assign ack_vld = vld_q;
   assign rd_data = vld_q ? data_q : '0;

endmodule

// File: rtl/reg_native_mem_target.sv
// Native-interface target that drives a fixed-latency single-port SRAM.
// One transaction in flight at a time. Defining REG_NATIVE_MEM_TARGET_ERR_EN
// adds an ack_err output flagging illegal wr_en/rd_en combinations.
module reg_native_mem_target
   import reg_native_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 128,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  ack_vld,
   input  logic                  ack_rdy,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  mem_ce,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef REG_NATIVE_MEM_TARGET_ERR_EN
   ,
   output logic                  ack_err
`endif
);

   if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
      $error("reg_native_mem_target: RD_LATENCY must be in 1..%0d", RD_LATENCY_MAX);
   end

   state_t                state, state_n;
   op_t                   op;
   logic [2:0]            cnt, cnt_n;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  accept;
   logic                  load;
   logic                  clear;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_err;

   // Control state: FSM, wait counter and the decoded operation.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
         op    <= OP_ILL;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            op <= decode_op(wr_en, rd_en);
         end
      end
   end

   // Request payload captured on the handshake; outputs are gated so no reset is needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= addr;
         wdata_q <= wr_data;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      accept    = 1'b0;
      load      = 1'b0;
      clear     = 1'b0;
      load_data = '0;
      load_err  = 1'b0;
      req_rdy   = 1'b0;
      mem_ce    = 1'b0;
      case (state)
         IDLE: begin
            req_rdy = rstn;
            if (req_vld && rstn) begin
               accept  = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            mem_ce = (op != OP_ILL);
            if (op == OP_RD) begin
               state_n = WAIT;
               cnt_n   = 3'd1;
            end else begin
               state_n  = ACK;
               load     = 1'b1;
               load_err = (op == OP_ILL);
            end
         end
         WAIT: begin
            cnt_n = cnt + 3'd1;
            if (cnt == 3'(RD_LATENCY)) begin
               state_n   = ACK;
               load      = 1'b1;
               load_data = mem_rdata;
            end
         end
         ACK: begin
            if (ack_rdy) begin
               state_n = IDLE;
               clear   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign mem_we    = mem_ce && (op == OP_WR);
   assign mem_addr  = mem_ce ? addr_q : '0;
   assign mem_wdata = mem_ce ? wdata_q : '0;

   reg_native_ack_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ack_buf (
      .clk       (clk),
      .rstn      (rstn),
      .load      (load),
      .clear     (clear),
      .load_data (load_data),
`ifdef REG_NATIVE_MEM_TARGET_ERR_EN
      .load_err  (load_err),
      .ack_err   (ack_err),
`endif
      .ack_vld   (ack_vld),
      .rd_data   (rd_data)
   );

`ifndef REG_NATIVE_MEM_TARGET_ERR_EN
   logic unused_load_err;
   assign unused_load_err = load_err;
`endif

endmodule

// File: tb/tb_reg_native_mem_target.sv
// Bench for reg_native_mem_target: three instances (RD_LATENCY 2, 1, 4), each
// with its own SRAM model, driven by directed and random transactions.
module tb_reg_native_mem_target;

   localparam int AW = 1;
   localparam int DW = 128;
   localparam int N  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic          req_vld [N];
   logic          req_rdy [N];
   logic          wr_en   [N];
   logic          rd_en   [N];
   logic [AW-1:0] addr    [N];
   logic [DW-1:0] wr_data [N];
   logic          ack_vld [N];
   logic          ack_rdy [N];
   logic [DW-1:0] rd_data [N];
   logic          mem_ce  [N];
   logic          mem_we  [N];
   logic [AW-1:0] mem_addr  [N];
   logic [DW-1:0] mem_wdata [N];
   logic [DW-1:0] mem_rdata [N];
   int            ce_cnt  [N];
`ifdef REG_NATIVE_MEM_TARGET_ERR_EN
   logic          ack_err [N];
`endif

   logic [DW-1:0] ref_mem [N][1<<AW];
   int passes = 0;
   int checks = 0;

   function automatic int lat_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         default: return 4;
      endcase
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [DW-1:0] mem  [1<<AW];
      logic [DW-1:0] pipe [L];
      int cnt = 0;

      reg_native_mem_target #(
         .ADDR_WIDTH (AW),
         .DATA_WIDTH (DW),
         .RD_LATENCY (L)
      ) u_dut (
         .clk       (clk),
         .rstn      (rstn),
         .req_vld   (req_vld[g]),
         .req_rdy   (req_rdy[g]),
         .wr_en     (wr_en[g]),
         .rd_en     (rd_en[g]),
         .addr      (addr[g]),
         .wr_data   (wr_data[g]),
         .ack_vld   (ack_vld[g]),
         .ack_rdy   (ack_rdy[g]),
         .rd_data   (rd_data[g]),
         .mem_ce    (mem_ce[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g])
`ifdef REG_NATIVE_MEM_TARGET_ERR_EN
         ,
         .ack_err   (ack_err[g])
`endif
      );

      // SRAM model: read data appears L cycles after the mem_ce edge, zero otherwise.
      always @(posedge clk) begin
         if (mem_ce[g]) begin
            cnt <= cnt + 1;
            if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
         end
         pipe[0] <= (mem_ce[g] && !mem_we[g]) ? mem[mem_addr[g]] : '0;
         for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end

      assign mem_rdata[g] = pipe[L-1];
      assign ce_cnt[g]    = cnt;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks = checks + 1;
      assert (obs === exp) passes = passes + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // op: 0 write, 1 read, 2 both enables, 3 no enable
   task automatic txn(input int i, input int op, input int a, input logic [DW-1:0] d, input int stall);
      int n;
      int ce0;
      int exp_lat;
      logic legal;
      logic [DW-1:0] exp_data;
      legal    = (op < 2);
      exp_lat  = (op == 1) ? 2 + lat_of(i) : 2;
      exp_data = (op == 1) ? ref_mem[i][a] : '0;
      @(negedge clk);
      req_vld[i] = 1'b1;
      wr_en[i]   = (op == 0 || op == 2);
      rd_en[i]   = (op == 1 || op == 2);
      addr[i]    = AW'(a);
      wr_data[i] = d;
      ack_rdy[i] = (stall == 0);
      n = 0;
      while (!req_rdy[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", DW'(n < 50), DW'(1));
      @(posedge clk);
      ce0 = ce_cnt[i];
      #1;
      req_vld[i] = 1'b0;
      wr_en[i]   = 1'($urandom);
      rd_en[i]   = 1'($urandom);
      addr[i]    = AW'($urandom);
      wr_data[i] = {$urandom, $urandom, $urandom, $urandom};
      if (op == 0) ref_mem[i][a] = d;
      @(negedge clk);
      chk("mem_ce", DW'(mem_ce[i]), DW'(legal));
      if (legal) begin
         chk("mem_we", DW'(mem_we[i]), DW'(op == 0));
         chk("mem_addr", DW'(mem_addr[i]), DW'(a));
         if (op == 0) chk("mem_wdata", mem_wdata[i], d);
      end
      n = 1;
      while (!ack_vld[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ack_latency", DW'(n), DW'(exp_lat));
      chk("rd_data", rd_data[i], exp_data);
      chk("req_rdy_busy", DW'(req_rdy[i]), '0);
`ifdef REG_NATIVE_MEM_TARGET_ERR_EN
      chk("ack_err", DW'(ack_err[i]), DW'(op >= 2));
`endif
      for (int s = 1; s < stall; s++) begin
         @(negedge clk);
         chk("hold_ack_vld", DW'(ack_vld[i]), DW'(1));
         chk("hold_rd_data", rd_data[i], exp_data);
         chk("hold_req_rdy", DW'(req_rdy[i]), '0);
      end
      ack_rdy[i] = 1'b1;
      @(negedge clk);
      chk("ack_clear", DW'(ack_vld[i]), '0);
      chk("req_rdy_back", DW'(req_rdy[i]), DW'(1));
      chk("ce_count", DW'(ce_cnt[i] - ce0), DW'(legal));
   endtask

   initial begin
      int n;
      int ce0;
      int seen;
      logic [DW-1:0] d1;

      rstn = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_vld[i] = 1'b0;
         wr_en[i]   = 1'b0;
         rd_en[i]   = 1'b0;
         addr[i]    = '0;
         wr_data[i] = '0;
         ack_rdy[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk("rst_req_rdy", DW'(req_rdy[i]), '0);
         chk("rst_ack_vld", DW'(ack_vld[i]), '0);
         chk("rst_mem_ce", DW'(mem_ce[i]), '0);
         chk("rst_mem_we", DW'(mem_we[i]), '0);
         chk("rst_mem_addr", DW'(mem_addr[i]), '0);
         chk("rst_mem_wdata", mem_wdata[i], '0);
         chk("rst_rd_data", rd_data[i], '0);
`ifdef REG_NATIVE_MEM_TARGET_ERR_EN
         chk("rst_ack_err", DW'(ack_err[i]), '0);
`endif
      end
      rstn = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) chk("rel_req_rdy", DW'(req_rdy[i]), DW'(1));

      // Fill every entry, then read back entry 0 at each latency.
      for (int i = 0; i < N; i++) begin
         txn(i, 0, 0, {32{4'ha}}, 0);
         txn(i, 0, 1, {32{4'hf}}, 0);
      end
      for (int i = 0; i < N; i++) txn(i, 1, 0, '0, 0);

      // Backpressure, illegal ops.
      txn(0, 1, 1, '0, 5);
      txn(0, 2, 1, {DW{1'b1}}, 0);
      txn(0, 3, 0, {DW{1'b1}}, 2);

      // Back-to-back: second request waits on req_vld through the first.
      d1 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      req_vld[0] = 1'b1; wr_en[0] = 1'b1; rd_en[0] = 1'b0;
      addr[0] = 1'b1; wr_data[0] = d1; ack_rdy[0] = 1'b1;
      n = 0;
      while (!req_rdy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_accept_wait", DW'(n < 50), DW'(1));
      @(posedge clk);
      ce0 = ce_cnt[0];
      #1;
      wr_en[0] = 1'b0; rd_en[0] = 1'b1; wr_data[0] = '0;
      ref_mem[0][1] = d1;
      @(negedge clk);
      chk("b2b_c1_req_rdy", DW'(req_rdy[0]), '0);
      @(negedge clk);
      chk("b2b_c2_ack_vld", DW'(ack_vld[0]), DW'(1));
      chk("b2b_c2_req_rdy", DW'(req_rdy[0]), '0);
      @(negedge clk);
      chk("b2b_c3_ack_vld", DW'(ack_vld[0]), '0);
      chk("b2b_c3_req_rdy", DW'(req_rdy[0]), DW'(1));
      @(posedge clk);
      #1;
      req_vld[0] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack_vld[0] && n < 40);
      chk("b2b_rd_latency", DW'(n), DW'(2 + lat_of(0)));
      chk("b2b_rd_data", rd_data[0], d1);
      @(negedge clk);
      chk("b2b_ack_clear", DW'(ack_vld[0]), '0);
      chk("b2b_ce_count", DW'(ce_cnt[0] - ce0), DW'(2));

      // Random traffic against the reference memory.
      for (int t = 0; t < 60; t++) begin
         int i, r, op;
         i  = $urandom_range(0, N - 1);
         r  = $urandom_range(0, 9);
         op = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
         txn(i, op, $urandom_range(0, 1), {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
      end

      // Reset while a read sits in WAIT.
      @(negedge clk);
      req_vld[0] = 1'b1; wr_en[0] = 1'b0; rd_en[0] = 1'b1;
      addr[0] = 1'b0; ack_rdy[0] = 1'b1;
      n = 0;
      while (!req_rdy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_accept_wait", DW'(n < 50), DW'(1));
      @(posedge clk);
      #1;
      req_vld[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_req_rdy", DW'(req_rdy[0]), '0);
      chk("mid_rst_ack_vld", DW'(ack_vld[0]), '0);
      chk("mid_rst_mem_ce", DW'(mem_ce[0]), '0);
      chk("mid_rst_mem_addr", DW'(mem_addr[0]), '0);
      chk("mid_rst_rd_data", rd_data[0], '0);
      rstn = 1'b1;
      @(negedge clk);
      chk("mid_rel_req_rdy", DW'(req_rdy[0]), DW'(1));
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack_vld[0] || mem_ce[0]) seen++;
      end
      chk("mid_rst_no_ack", DW'(seen), '0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/reg_native_mem_target.md
Name: reg_native_mem_target

Overview:
- Target-side adapter sitting directly downstream of a regslv external-memory port (reg_native_if: req_vld/req_rdy, ack_vld/ack_rdy, wr_en, rd_en, addr, wr_data, rd_data).
- Converts one native-if transaction at a time into strobes for a synchronous single-port SRAM with fixed read latency.
- Holds the acknowledge and read data until the upstream snapshot logic takes them.
- Replaces behavioural memory models in real integrations.

Parameters:
ADDR_WIDTH, 1, native/SRAM address width; MEM_ENTRY = 1<<ADDR_WIDTH entries.
DATA_WIDTH, 128, native and SRAM data width.
RD_LATENCY, 1, SRAM read latency in cycles, legal 1..4 (elaboration error otherwise).

Ports:
clk  input  1  clock
rstn  input  1  synchronous reset, active low
req_vld  input  1  request valid
req_rdy  output  1  request ready
wr_en  input  1  write request, qualified by req_vld
rd_en  input  1  read request, qualified by req_vld
addr  input  ADDR_WIDTH  entry address
wr_data  input  DATA_WIDTH  write data
ack_vld  output  1  acknowledge valid
ack_rdy  input  1  acknowledge ready
rd_data  output  DATA_WIDTH  read data, valid with ack_vld
mem_ce  output  1  SRAM chip enable, one-cycle pulse
mem_we  output  1  SRAM write enable, valid with mem_ce
mem_addr  output  ADDR_WIDTH  SRAM address
mem_wdata  output  DATA_WIDTH  SRAM write data
mem_rdata  input  DATA_WIDTH  SRAM read data, valid RD_LATENCY cycles after the mem_ce edge

Behaviour:
- Clocking and reset: one clock, clk. Reset rstn is synchronous and active low. All state is updated only on posedge clk.
- Reset values: state IDLE; req_rdy=0 while rstn=0, and 1 in the first cycle after release; all other outputs 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: req_rdy=1. On req_vld&req_rdy, latch op, addr and wr_data, then go to ISSUE.
- ISSUE: drive mem_ce=1 for exactly one cycle, with mem_we=op_wr, mem_addr and mem_wdata. Writes go to ACK. Reads go to WAIT with cnt=1.
- WAIT: cnt increments each cycle. When cnt==RD_LATENCY, capture mem_rdata into rd_data and go to ACK.
- ACK: ack_vld=1; rd_data and ack_vld held stable until ack_rdy. On ack_vld&ack_rdy, go to IDLE and clear ack_vld next cycle.
- Latency from accept edge to first ack_vld cycle: write 2 cycles; read 2+RD_LATENCY cycles.
- Write ack: rd_data driven all-zero.
- ack_rdy already high on entry to ACK: ack_vld lasts exactly one cycle.
- Back-to-back requests: req_rdy is low outside IDLE, so the next request is accepted one cycle after the ack handshake. Throughput is one transaction per 3 (write) or 3+RD_LATENCY (read) cycles.
- Illegal op: wr_en&rd_en both high, or neither high, with req_vld. The request is accepted, no mem_ce is issued, and the FSM goes straight from ISSUE to ACK with rd_data=0.
- req_vld deasserted while req_rdy=0: ignored; only the handshake cycle is sampled.
- Reset mid-transaction: on the rstn-low edge, the in-flight operation is dropped, mem_ce is deasserted, and no ack is issued.
- Address wrap: none needed; every addr value maps to a valid entry.

Optional Feature:
- Macro: REG_NATIVE_MEM_TARGET_ERR_EN.
- Defined: adds output ack_err (1 bit, reset 0). It is asserted alongside ack_vld for the illegal-op case and holds with ack_vld.
- Undefined: no ack_err port. Illegal ops complete silently as described under Behaviour.

Decomposition:
- Package reg_native_mem_pkg:
  - typedef enum for state {IDLE, ISSUE, WAIT, ACK};
  - typedef enum for op {OP_WR, OP_RD, OP_ILL};
  - constant RD_LATENCY_MAX=4;
  - function decode_op(wr_en, rd_en).
- Sub-module reg_native_ack_buf: holds ack_vld/rd_data (and ack_err) until ack_rdy; load and clear ports driven by the FSM.

Test Plan:
- Write: RD_LATENCY=2; req addr=1, wr_data=128'hffff...ff, wr_en=1, ack_rdy=1 -> mem_ce&mem_we one cycle after accept with addr 1; ack_vld 2 cycles after accept; rd_data=0.
- Read latency: SRAM entry 0=128'haaaa...aa, RD_LATENCY=2, read addr 0 -> ack_vld exactly 4 cycles after accept, rd_data=128'haaaa...aa. Repeat with RD_LATENCY=1 -> 3 cycles; RD_LATENCY=4 -> 6 cycles.
- Backpressure: read completes with ack_rdy=0 for 5 cycles -> ack_vld and rd_data stable all 5 cycles, req_rdy=0 throughout; ack_rdy=1 -> ack_vld=0 and req_rdy=1 next cycle.
- Back-to-back: second request held on req_vld during the first transaction -> accepted exactly one cycle after the first ack handshake; no overlapping mem_ce.
- Illegal op: wr_en=rd_en=1 -> no mem_ce; ack after 2 cycles with rd_data=0; with REG_NATIVE_MEM_TARGET_ERR_EN, ack_err=1.
- Reset mid-read: rstn=0 during WAIT for one cycle -> next cycle all outputs 0, no ack issued; first cycle after release req_rdy=1.
